// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment display arbiter:
// display state encoding, active-low idle constants and the hex glyph table.
package seg_pkg;

    typedef enum logic [1:0] {
        ST_BLANK = 2'd0,
        ST_LIVE  = 2'd1,
        ST_HOLD  = 2'd2
    } disp_state_t;

    // Everything on the pins is active-low, so "off" is all ones.
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [3:0] AN_OFF    = 4'hF;

    // Active-low glyphs, seg[6:0] = {g,f,e,d,c,b,a}; entry 0 is the rightmost.
    localparam logic [15:0][6:0] HEX_SEG_TABLE = {
        7'h0E,  // F
        7'h06,  // E
        7'h21,  // d
        7'h46,  // C
        7'h03,  // b
        7'h08,  // A
        7'h10,  // 9
        7'h00,  // 8
        7'h78,  // 7
        7'h02,  // 6
        7'h12,  // 5
        7'h19,  // 4
        7'h30,  // 3
        7'h24,  // 2
        7'h79,  // 1
        7'h40   // 0
    };

endpackage

// File: rtl/seg_display_arbiter_hex_to_seg.sv
// Combinational hex nibble to active-low seven-segment decoder.
// Shared with the quad-display path, so it stays free of any state.
module hex_to_seg
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    // Plain table lookup covering all sixteen hex values.
    always_comb begin
        seg = HEX_SEG_TABLE[nibble];
    end

endmodule

// File: rtl/seg_display_arbiter.sv
// Four-digit seven-segment display owner shared between the UART rx path,
// the UART tx path and a host/debug port that can take the whole display
// for a fixed hold time. Rx/tx bytes are always shadowed so nothing is lost
// while the host owns the display. Digit scanning uses a single-clock
// prescaler; every pin output is registered.
module seg_display_arbiter
    import seg_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int HOLD_CYCLES = 200000000,
    parameter int FLASH_LEN   = 25000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    input  logic        tx_valid,
    input  logic [7:0]  tx_data,
    input  logic        host_valid,
    input  logic [15:0] host_data,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an,
    output logic        host_busy
);

    localparam int PRE_W   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int HOLD_W  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int FLASH_W = $clog2(FLASH_LEN + 1);

    localparam logic [PRE_W-1:0]   PRE_LAST   = PRE_W'(REFRESH_DIV - 1);
    localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [FLASH_W-1:0] FLASH_LOAD = FLASH_W'(FLASH_LEN);

    disp_state_t         state_q, state_d;
    logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [PRE_W-1:0]    pre_cnt_q, pre_cnt_d;
    logic [1:0]          idx_q, idx_d;
    logic [7:0]          rx_byte_q, rx_byte_d;
    logic [7:0]          tx_byte_q, tx_byte_d;
    logic [15:0]         host_word_q, host_word_d;
    logic                seen_any_q, seen_any_d;
    logic [FLASH_W-1:0]  rx_flash_q, rx_flash_d;
    logic [FLASH_W-1:0]  tx_flash_q, tx_flash_d;
    logic [6:0]          seg_q, seg_d;
    logic                dp_q, dp_d;
    logic [3:0]          an_q, an_d;
    logic                host_busy_q, host_busy_d;

    logic [15:0] live_word;
    logic [3:0]  live_nib [4];
    logic [3:0]  host_nib [4];
    logic [3:0]  sel_nib;
    logic [6:0]  dec_seg;

    // Live image: tx byte on the left pair, rx byte on the right pair.
    assign live_word = {tx_byte_q, rx_byte_q};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_nib
            assign live_nib[gi] = live_word[gi*4 +: 4];
            assign host_nib[gi] = host_word_q[gi*4 +: 4];
        end
    endgenerate

    // Pick the nibble for the currently scanned digit from the active image.
    always_comb begin
        sel_nib = live_nib[idx_q];
        if (state_q == ST_HOLD) begin
            sel_nib = host_nib[idx_q];
        end
    end

    hex_to_seg u_hex_to_seg (
        .nibble (sel_nib),
        .seg    (dec_seg)
    );

    // Shadow registers, seen flag and decimal-point flash timers.
    always_comb begin
        rx_byte_d   = rx_valid   ? rx_data   : rx_byte_q;
        tx_byte_d   = tx_valid   ? tx_data   : tx_byte_q;
        host_word_d = host_valid ? host_data : host_word_q;
        seen_any_d  = seen_any_q | rx_valid | tx_valid;

        rx_flash_d = rx_flash_q;
        if (rx_valid) begin
            rx_flash_d = FLASH_LOAD;
        end else if (rx_flash_q != '0) begin
            rx_flash_d = rx_flash_q - FLASH_W'(1);
        end

        tx_flash_d = tx_flash_q;
        if (tx_valid) begin
            tx_flash_d = FLASH_LOAD;
        end else if (tx_flash_q != '0) begin
            tx_flash_d = tx_flash_q - FLASH_W'(1);
        end
    end

    // Free-running digit scan; it never restarts on state changes.
    always_comb begin
        pre_cnt_d = pre_cnt_q + PRE_W'(1);
        idx_d     = idx_q;
        if (pre_cnt_q == PRE_LAST) begin
            pre_cnt_d = '0;
            idx_d     = idx_q + 2'd1;
        end
    end

    // Ownership FSM. A host write always wins, including on the expiry cycle.
    // Expiry looks at seen_any_d so a byte arriving that very cycle still
    // brings the live image back rather than a dark display.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        if (host_valid) begin
            state_d    = ST_HOLD;
            hold_cnt_d = '0;
        end else begin
            case (state_q)
                ST_BLANK: begin
                    if (rx_valid || tx_valid) begin
                        state_d = ST_LIVE;
                    end
                end
                ST_LIVE: begin
                    state_d = ST_LIVE;
                end
                ST_HOLD: begin
                    if (hold_cnt_q == HOLD_LAST) begin
                        state_d    = seen_any_d ? ST_LIVE : ST_BLANK;
                        hold_cnt_d = '0;
                    end else begin
                        hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                    end
                end
                default: begin
                    state_d    = ST_BLANK;
                    hold_cnt_d = '0;
                end
            endcase
        end
    end

    // Next pin values; dark in BLANK, decimal points only flash in LIVE.
    always_comb begin
        seg_d       = SEG_BLANK;
        dp_d        = 1'b1;
        an_d        = AN_OFF;
        host_busy_d = (state_q == ST_HOLD);
        if (state_q == ST_LIVE || state_q == ST_HOLD) begin
            an_d  = ~(4'b0001 << idx_q);
            seg_d = dec_seg;
        end
        if (state_q == ST_LIVE) begin
            if ((idx_q == 2'd0 && rx_flash_q != '0) ||
                (idx_q == 2'd2 && tx_flash_q != '0)) begin
                dp_d = 1'b0;
            end
        end
    end

    // All state and pin registers; reset drops the pins to their idle values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_BLANK;
            hold_cnt_q  <= '0;
            pre_cnt_q   <= '0;
            idx_q       <= '0;
            rx_byte_q   <= '0;
            tx_byte_q   <= '0;
            host_word_q <= '0;
            seen_any_q  <= 1'b0;
            rx_flash_q  <= '0;
            tx_flash_q  <= '0;
            seg_q       <= SEG_BLANK;
            dp_q        <= 1'b1;
            an_q        <= AN_OFF;
            host_busy_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_cnt_q  <= hold_cnt_d;
            pre_cnt_q   <= pre_cnt_d;
            idx_q       <= idx_d;
            rx_byte_q   <= rx_byte_d;
            tx_byte_q   <= tx_byte_d;
            host_word_q <= host_word_d;
            seen_any_q  <= seen_any_d;
            rx_flash_q  <= rx_flash_d;
            tx_flash_q  <= tx_flash_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
            an_q        <= an_d;
            host_busy_q <= host_busy_d;
        end
    end

    assign seg       = seg_q;
    assign dp        = dp_q;
    assign an        = an_q;
    assign host_busy = host_busy_q;

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Self-checking bench for seg_display_arbiter. A time-stamp based model
// (edges since reset, edge of last strobe, hold start edge) predicts the
// pins every cycle; directed sequences pin literal glyphs and hold lengths.
module tb_seg_display_arbiter;

    localparam int R = 4;
    localparam int H = 64;
    localparam int F = 100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        tx_valid = 1'b0;
    logic [7:0]  tx_data = 8'h00;
    logic        host_valid = 1'b0;
    logic [15:0] host_data = 16'h0000;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        host_busy;

    int checks = 0;
    int errors = 0;

    seg_display_arbiter #(
        .REFRESH_DIV (R),
        .HOLD_CYCLES (H),
        .FLASH_LEN   (F)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .host_valid (host_valid),
        .host_data  (host_data),
        .seg        (seg),
        .dp         (dp),
        .an         (an),
        .host_busy  (host_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    // Active-low glyph for a hex value, segments {g,f,e,d,c,b,a}.
    function automatic logic [6:0] ref_seg(input int v);
        case (v)
            0: return 7'h40;   1: return 7'h79;   2: return 7'h24;   3: return 7'h30;
            4: return 7'h19;   5: return 7'h12;   6: return 7'h02;   7: return 7'h78;
            8: return 7'h00;   9: return 7'h10;   10: return 7'h08;  11: return 7'h03;
            12: return 7'h46;  13: return 7'h21;  14: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    // ---------------- behavioural model ----------------
    // mode: 0 dark, 1 live image, 2 host image
    int          m_n, m_mode, m_hold_start, m_rx_e, m_tx_e, m_idx, m_nib;
    bit          m_seen, m_rx_ever, m_tx_ever;
    logic [7:0]  m_rx, m_tx;
    logic [15:0] m_host, m_word;
    logic [6:0]  e_seg;
    logic        e_dp, e_busy;
    logic [3:0]  e_an;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_n = 0; m_mode = 0; m_hold_start = 0; m_rx_e = 0; m_tx_e = 0;
            m_seen = 0; m_rx_ever = 0; m_tx_ever = 0;
            m_rx = 8'h00; m_tx = 8'h00; m_host = 16'h0000;
            e_seg = 7'h7F; e_dp = 1'b1; e_an = 4'hF; e_busy = 1'b0;
        end else begin
            // pins after this edge reflect the situation before it
            m_idx  = (m_n / R) % 4;
            e_busy = (m_mode == 2);
            e_seg  = 7'h7F; e_dp = 1'b1; e_an = 4'hF;
            if (m_mode != 0) begin
                m_word = (m_mode == 2) ? m_host : {m_tx, m_rx};
                m_nib  = int'((m_word >> (4 * m_idx)) & 16'h000F);
                e_seg  = ref_seg(m_nib);
                e_an   = 4'hF & ~(4'b0001 << m_idx);
                if (m_mode == 1 &&
                    ((m_idx == 0 && m_rx_ever && (m_n - m_rx_e) < F) ||
                     (m_idx == 2 && m_tx_ever && (m_n - m_tx_e) < F)))
                    e_dp = 1'b0;
            end
            if (rx_valid || tx_valid) m_seen = 1;
            if (host_valid) begin
                m_mode = 2; m_hold_start = m_n + 1; m_host = host_data;
            end else if (m_mode == 2 && (m_n - m_hold_start) == H - 1) begin
                m_mode = m_seen ? 1 : 0;
            end else if (m_mode == 0 && (rx_valid || tx_valid)) begin
                m_mode = 1;
            end
            if (rx_valid) begin m_rx = rx_data; m_rx_e = m_n + 1; m_rx_ever = 1; end
            if (tx_valid) begin m_tx = tx_data; m_tx_e = m_n + 1; m_tx_ever = 1; end
            m_n++;
        end
    end

    // Every-cycle comparison of the pins against the model.
    always @(negedge clk) begin
        check("seg_model", {25'd0, seg}, {25'd0, e_seg});
        check("dp_model", {31'd0, dp}, {31'd0, e_dp});
        check("an_model", {28'd0, an}, {28'd0, e_an});
        check("busy_model", {31'd0, host_busy}, {31'd0, e_busy});
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_rx(input logic [7:0] d);
        @(negedge clk); rx_valid = 1'b1; rx_data = d;
        $display("rx   data=%h", d);
        @(negedge clk); rx_valid = 1'b0;
    endtask

    task automatic send_tx(input logic [7:0] d);
        @(negedge clk); tx_valid = 1'b1; tx_data = d;
        $display("tx   data=%h", d);
        @(negedge clk); tx_valid = 1'b0;
    endtask

    task automatic send_host(input logic [15:0] d);
        @(negedge clk); host_valid = 1'b1; host_data = d;
        $display("host data=%h", d);
        @(negedge clk); host_valid = 1'b0;
    endtask

    // Async reset asserted between edges; pins must idle before any edge.
    task automatic do_reset(input string name);
        @(negedge clk);
        rx_valid = 1'b0; tx_valid = 1'b0; host_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check({name, "_seg"}, {25'd0, seg}, 32'h7F);
        check({name, "_dp"}, {31'd0, dp}, 32'h1);
        check({name, "_an"}, {28'd0, an}, 32'hF);
        check({name, "_busy"}, {31'd0, host_busy}, 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        $display("reset %s released", name);
    endtask

    // Wait (bounded) for digit d to be scanned, then check its glyph/dp.
    task automatic check_digit(input string name, input int d, input logic [6:0] s,
                               input bit chk_dp, input logic dpv);
        bit found;
        found = 0;
        for (int i = 0; i < 8 * R + 4; i++) begin
            @(negedge clk);
            if (an == (4'hF & ~(4'b0001 << d))) begin found = 1; break; end
        end
        check({name, "_found"}, {31'd0, found}, 32'h1);
        check({name, "_seg"}, {25'd0, seg}, {25'd0, s});
        if (chk_dp) check({name, "_dp"}, {31'd0, dp}, {31'd0, dpv});
    endtask

    // Host write, optional second write k edges later, optional rx during
    // the hold; measures how many cycles host_busy stays high.
    task automatic hold_run(input string name, input logic [15:0] w, input int k,
                            input bit do_rx, input int exp_cnt,
                            input logic [6:0] s3, input logic [6:0] s0);
        int cnt;
        bit got3, got0;
        cnt = 0; got3 = 0; got0 = 0;
        send_host(w);
        for (int i = 1; i <= 4 * H; i++) begin
            @(negedge clk);
            host_valid = (k > 0 && i == k - 1);
            if (host_valid) begin host_data = w; $display("host data=%h (restart)", w); end
            rx_valid = (do_rx && i == 5);
            if (rx_valid) begin rx_data = 8'h12; $display("rx   data=12 (during hold)"); end
            if (host_busy) begin
                cnt++;
                if (!got3 && an == 4'b0111) begin got3 = 1; check({name, "_d3"}, {25'd0, seg}, {25'd0, s3}); end
                if (!got0 && an == 4'b1110) begin got0 = 1; check({name, "_d0"}, {25'd0, seg}, {25'd0, s0}); end
            end else if (cnt > 0) begin
                break;
            end
        end
        host_valid = 1'b0; rx_valid = 1'b0;
        check({name, "_busy_cycles"}, cnt, exp_cnt);
    endtask

    initial begin
        // reset check: idle for five scan slots after release
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5 * R) @(negedge clk);
        check("idle_an", {28'd0, an}, 32'hF);
        check("idle_seg", {25'd0, seg}, 32'h7F);
        check("idle_dp", {31'd0, dp}, 32'h1);
        check("idle_busy", {31'd0, host_busy}, 32'h0);

        // basic display: 5A / 41 with flashing points on digits 0 and 2
        send_rx(8'h41);
        send_tx(8'h5A);
        check_digit("basic_d0", 0, 7'h79, 1, 1'b0);
        check_digit("basic_d1", 1, 7'h19, 1, 1'b1);
        check_digit("basic_d2", 2, 7'h08, 1, 1'b0);
        check_digit("basic_d3", 3, 7'h12, 1, 1'b1);
        repeat (F + 4) @(negedge clk);
        check_digit("flash_end_d0", 0, 7'h79, 1, 1'b1);
        check_digit("flash_end_d2", 2, 7'h08, 1, 1'b1);

        // host hold with an rx byte arriving while busy
        do_reset("rst_hold");
        hold_run("hold", 16'hBEEF, 0, 1, H, 7'h03, 7'h0E);
        check_digit("after_hold_d0", 0, 7'h24, 0, 1'b1);
        check_digit("after_hold_d1", 1, 7'h79, 0, 1'b1);
        check_digit("after_hold_d2", 2, 7'h40, 0, 1'b1);

        // restart late in the hold, from BLANK: ends dark again
        do_reset("rst_restart");
        hold_run("restart", 16'h1234, H - 10, 0, 2 * H - 10, 7'h79, 7'h19);
        repeat (2 * R) @(negedge clk);
        check("blank_after_an", {28'd0, an}, 32'hF);
        check("blank_after_seg", {25'd0, seg}, 32'h7F);

        // host write landing exactly on the expiry cycle
        do_reset("rst_expiry");
        hold_run("expiry", 16'hC0DE, H, 0, 2 * H, 7'h46, 7'h06);

        // mid-hold asynchronous reset; shadows must be cleared
        do_reset("rst_pre");
        send_rx(8'hA5);
        send_tx(8'h3C);
        send_host(16'hBEEF);
        repeat (H / 2) @(negedge clk);
        do_reset("rst_midhold");
        send_tx(8'h77);
        check_digit("post_rst_d0", 0, 7'h40, 0, 1'b1);
        check_digit("post_rst_d1", 1, 7'h40, 0, 1'b1);
        check_digit("post_rst_d2", 2, 7'h78, 0, 1'b1);

        // randomized traffic against the model
        do_reset("rst_random");
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            rx_valid   = ($urandom_range(15) == 0);
            tx_valid   = ($urandom_range(15) == 0);
            host_valid = ($urandom_range(299) == 0);
            rx_data    = 8'($urandom);
            tx_data    = 8'($urandom);
            host_data  = 16'($urandom);
            if (rx_valid)   $display("rx   data=%h", rx_data);
            if (tx_valid)   $display("tx   data=%h", tx_data);
            if (host_valid) $display("host data=%h", host_data);
        end
        @(negedge clk);
        rx_valid = 1'b0; tx_valid = 1'b0; host_valid = 1'b0;
        repeat (H + 8) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
